// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/EXEC1/EXEC2/HALT sequencer with memory and multiply/divide stall handling.
// Optional retired-instruction counter built only when CPU_SEQ_RETIRE_COUNT_EN is defined.

package codes;
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC1 = 2'd1,
      EXEC2 = 2'd2,
      HALT  = 2'd3
   } state_t;
endpackage

module cpu_sequencer #(
   parameter int unsigned RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ram_access_i,
   input  logic                ram_waitrequest_i,
   input  logic                muldiv_start_i,
   input  logic                muldiv_done_i,
   input  logic                halt_req_i,
   output codes::state_t       state_o,
   output logic                active_o,
   output logic                stall_o,
   output logic                commit_o,
   output logic [RETIRE_W-1:0] retired_o
);
   import codes::*;

   state_t state_q, state_d;
   logic   active_q, active_d;
   logic   pending_q, pending_d;
   logic   mem_stall, md_stall, stall;

   always_comb begin
      mem_stall = ram_access_i & ram_waitrequest_i & active_q;
      md_stall  = (state_q == EXEC2) &
                  ((muldiv_start_i & ~pending_q) | (pending_q & ~muldiv_done_i));
      stall     = mem_stall | md_stall;
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      // A done pulse only counts once the start has been latched into pending.
      if ((state_q == EXEC2) && muldiv_start_i && !pending_q) begin
         pending_d = 1'b1;
      end else if (pending_q && muldiv_done_i) begin
         pending_d = 1'b0;
      end
      if (!stall) begin
         unique case (state_q)
            FETCH:   state_d = EXEC1;
            EXEC1:   state_d = EXEC2;
            EXEC2:   state_d = halt_req_i ? HALT : FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
         endcase
      end
      active_d = (state_d != HALT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= FETCH;
         active_q  <= 1'b1;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         pending_q <= pending_d;
      end
   end

`ifdef CPU_SEQ_RETIRE_COUNT_EN
   logic                retire;
   logic [RETIRE_W-1:0] retired_q, retired_d;

   always_comb begin
      retire    = (state_q == EXEC2) & ~stall;
      retired_d = retire ? retired_q + RETIRE_W'(1) : retired_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retired_q <= '0;
      end else begin
         retired_q <= retired_d;
      end
   end

   assign retired_o = retired_q;
`else
   assign retired_o = '0;
`endif

   assign state_o  = state_q;
   assign active_o = active_q;
   assign stall_o  = stall;
   assign commit_o = active_q & ~stall;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: sequencing, memory stall, muldiv, halt, reset, counter wrap.
// Expected retired_o follows CPU_SEQ_RETIRE_COUNT_EN; the DUT is built with RETIRE_W=4.

module tb_cpu_sequencer;
   import codes::*;

`ifdef CPU_SEQ_RETIRE_COUNT_EN
   localparam bit CNT = 1'b1;
`else
   localparam bit CNT = 1'b0;
`endif

   // Stimulus vector bits: {ram_access, waitrequest, muldiv_start, muldiv_done, halt_req}
   localparam logic [4:0] I_NONE = 5'b00000;
   localparam logic [4:0] I_MEM  = 5'b11000;
   localparam logic [4:0] I_ACC  = 5'b10000;
   localparam logic [4:0] I_WT   = 5'b01000;
   localparam logic [4:0] I_ST   = 5'b00100;
   localparam logic [4:0] I_DN   = 5'b00010;
   localparam logic [4:0] I_HR   = 5'b00001;

   logic       clk;
   logic       reset;
   logic       ram_access_i;
   logic       ram_waitrequest_i;
   logic       muldiv_start_i;
   logic       muldiv_done_i;
   logic       halt_req_i;
   state_t     state_o;
   logic       active_o;
   logic       stall_o;
   logic       commit_o;
   logic [3:0] retired_o;

   int n_tests = 0;
   int n_fail  = 0;

   cpu_sequencer #(
      .RETIRE_W (4)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .ram_access_i      (ram_access_i),
      .ram_waitrequest_i (ram_waitrequest_i),
      .muldiv_start_i    (muldiv_start_i),
      .muldiv_done_i     (muldiv_done_i),
      .halt_req_i        (halt_req_i),
      .state_o           (state_o),
      .active_o          (active_o),
      .stall_o           (stall_o),
      .commit_o          (commit_o),
      .retired_o         (retired_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [4:0] s);
      {ram_access_i, ram_waitrequest_i, muldiv_start_i, muldiv_done_i, halt_req_i} = s;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 4 time units into the first post-reset (FETCH) cycle.
   task automatic do_reset();
      @(posedge clk);
      #1;
      drive(I_NONE);
      reset = 1'b1;
      #3;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      drive(I_NONE);
      reset = 1'b0;
      #1;
      reset = 1'b1;
      #2;
      n_tests++;
      if (state_o !== FETCH || active_o !== 1'b1 || stall_o !== 1'b0 || commit_o !== 1'b1 ||
          retired_o !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_values: state=%0d active=%b stall=%b commit=%b retired=%0d, want 0 1 0 1 0",
                  state_o, active_o, stall_o, commit_o, retired_o);
      end
      drive(I_MEM);
      #1;
      n_tests++;
      if (stall_o !== 1'b1 || commit_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_comb_stall: stall=%b commit=%b, want 1 0", stall_o, commit_o);
      end
      next_cycle();
      n_tests++;
      if (state_o !== FETCH || active_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_held: state=%0d active=%b, want 0 1", state_o, active_o);
      end
      drive(I_NONE);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      state_t exp_st;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         exp_st = (i % 3 == 0) ? FETCH : ((i % 3 == 1) ? EXEC1 : EXEC2);
         #1;
         n_tests++;
         if (state_o !== exp_st || stall_o !== 1'b0 || commit_o !== 1'b1 || active_o !== 1'b1) begin
            n_fail++;
            $display("FAIL basic cyc %0d: state=%0d stall=%b commit=%b active=%b, want %0d 0 1 1",
                     i, state_o, stall_o, commit_o, active_o, exp_st);
         end
         next_cycle();
      end
      n_tests++;
      if (retired_o !== (CNT ? 4'd3 : 4'd0) || state_o !== FETCH) begin
         n_fail++;
         $display("FAIL basic_retired: retired=%0d state=%0d, want %0d 0",
                  retired_o, state_o, CNT ? 3 : 0);
      end
   endtask

   task automatic test_mem_stall();
      logic [4:0] stim [5];
      state_t     st   [5];
      logic       stl  [5];
      stim = '{I_NONE, I_MEM, I_MEM, I_ACC, I_WT};
      st   = '{FETCH, EXEC1, EXEC1, EXEC1, EXEC2};
      stl  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(stim[i]);
         #1;
         n_tests++;
         if (state_o !== st[i] || stall_o !== stl[i] || commit_o !== ~stl[i] ||
             retired_o !== 4'd0) begin
            n_fail++;
            $display("FAIL mem_stall cyc %0d: state=%0d stall=%b commit=%b retired=%0d, want %0d %b %b 0",
                     i, state_o, stall_o, commit_o, retired_o, st[i], stl[i], ~stl[i]);
         end
         next_cycle();
      end
      drive(I_NONE);
      #1;
      n_tests++;
      if (state_o !== FETCH || retired_o !== (CNT ? 4'd1 : 4'd0)) begin
         n_fail++;
         $display("FAIL mem_stall_end: state=%0d retired=%0d, want 0 %0d",
                  state_o, retired_o, CNT ? 1 : 0);
      end
   endtask

   task automatic test_muldiv();
      logic [4:0] stim [10];
      state_t     st   [10];
      logic       stl  [10];
      logic [3:0] ret  [10];
      // Done coinciding with the start cycle must be ignored; start is held while pending.
      stim = '{I_NONE, I_NONE, I_ST | I_DN, I_ST, I_ST, I_ST, I_ST | I_DN, I_NONE, I_NONE, I_NONE};
      st   = '{FETCH, EXEC1, EXEC2, EXEC2, EXEC2, EXEC2, EXEC2, FETCH, EXEC1, EXEC2};
      stl  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      ret  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(stim[i]);
         #1;
         n_tests++;
         if (state_o !== st[i] || stall_o !== stl[i] || commit_o !== ~stl[i] ||
             retired_o !== (CNT ? ret[i] : 4'd0)) begin
            n_fail++;
            $display("FAIL muldiv cyc %0d: state=%0d stall=%b commit=%b retired=%0d, want %0d %b %b %0d",
                     i, state_o, stall_o, commit_o, retired_o, st[i], stl[i], ~stl[i],
                     CNT ? ret[i] : 4'd0);
         end
         next_cycle();
      end
      drive(I_NONE);
   endtask

   task automatic test_halt();
      logic [4:0] stim [14];
      state_t     st   [14];
      logic       stl  [14];
      logic       act  [14];
      logic [3:0] ret  [14];
      stim = '{I_HR, I_HR, I_NONE, I_NONE, I_NONE, I_MEM | I_HR, I_NONE, I_NONE, I_NONE, I_HR,
               I_MEM | I_HR, I_ST | I_HR, I_MEM | I_ST | I_DN, I_HR};
      st   = '{FETCH, EXEC1, EXEC2, FETCH, EXEC1, EXEC2, EXEC2, FETCH, EXEC1, EXEC2,
               HALT, HALT, HALT, HALT};
      stl  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0};
      act  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0};
      ret  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2,
               4'd3, 4'd3, 4'd3, 4'd3};
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive(stim[i]);
         #1;
         n_tests++;
         if (state_o !== st[i] || stall_o !== stl[i] || active_o !== act[i] ||
             commit_o !== (act[i] & ~stl[i]) || retired_o !== (CNT ? ret[i] : 4'd0)) begin
            n_fail++;
            $display("FAIL halt cyc %0d: state=%0d stall=%b active=%b commit=%b retired=%0d, want %0d %b %b %b %0d",
                     i, state_o, stall_o, active_o, commit_o, retired_o, st[i], stl[i], act[i],
                     act[i] & ~stl[i], CNT ? ret[i] : 4'd0);
         end
         next_cycle();
      end
      drive(I_NONE);
   endtask

   task automatic test_reset_muldiv();
      logic [4:0] stim [7];
      state_t     st   [7];
      logic       stl  [7];
      logic [4:0] stim2 [4];
      state_t     st2   [4];
      stim  = '{I_NONE, I_NONE, I_NONE, I_NONE, I_NONE, I_ST, I_ST};
      st    = '{FETCH, EXEC1, EXEC2, FETCH, EXEC1, EXEC2, EXEC2};
      stl   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      stim2 = '{I_DN, I_NONE, I_NONE, I_NONE};
      st2   = '{FETCH, EXEC1, EXEC2, FETCH};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(stim[i]);
         #1;
         n_tests++;
         if (state_o !== st[i] || stall_o !== stl[i]) begin
            n_fail++;
            $display("FAIL rst_md_pre cyc %0d: state=%0d stall=%b, want %0d %b",
                     i, state_o, stall_o, st[i], stl[i]);
         end
         if (i < 6) next_cycle();
      end
      // Mid-cycle while pending: asynchronous return to FETCH.
      #1;
      reset = 1'b1;
      drive(I_NONE);
      #1;
      n_tests++;
      if (state_o !== FETCH || active_o !== 1'b1 || stall_o !== 1'b0 || retired_o !== 4'd0) begin
         n_fail++;
         $display("FAIL rst_md_async: state=%0d active=%b stall=%b retired=%0d, want 0 1 0 0",
                  state_o, active_o, stall_o, retired_o);
      end
      next_cycle();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(stim2[i]);
         #1;
         n_tests++;
         if (state_o !== st2[i] || stall_o !== 1'b0 || commit_o !== 1'b1 ||
             retired_o !== ((CNT && i == 3) ? 4'd1 : 4'd0)) begin
            n_fail++;
            $display("FAIL rst_md_post cyc %0d: state=%0d stall=%b commit=%b retired=%0d, want %0d 0 1 %0d",
                     i, state_o, stall_o, commit_o, retired_o, st2[i], (CNT && i == 3) ? 1 : 0);
         end
         next_cycle();
      end
      drive(I_NONE);
   endtask

   task automatic test_counter_wrap();
      logic [3:0] exp_ret;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         next_cycle();
         next_cycle();
         next_cycle();
         exp_ret = CNT ? 4'((k + 1) % 16) : 4'd0;
         if (k == 14 || k == 15 || !CNT) begin
            n_tests++;
            if (retired_o !== exp_ret || state_o !== FETCH) begin
               n_fail++;
               $display("FAIL wrap instr %0d: retired=%0d state=%0d, want %0d 0",
                        k + 1, retired_o, state_o, exp_ret);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mem_stall();
      test_muldiv();
      test_halt();
      test_reset_muldiv();
      test_counter_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle state sequencer for the MIPS core. It drives the `state_t` value consumed by the instruction-decode control block and walks FETCH -> EXEC1 -> EXEC2 per instruction. It holds the current state while memory asserts waitrequest or a multiply/divide is in flight, and parks the core in HALT when the halt condition is signalled. It also produces the commit strobe that the datapath ANDs into the PC, IR, register-file and RAM write enables.

## Interface
Parameters:
- `RETIRE_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ram_access_i`  in  1  control block requests a RAM read or write this cycle.
- `ram_waitrequest_i`  in  1  memory not ready; meaningful only while `ram_access_i`=1.
- `muldiv_start_i`  in  1  EXEC2 of a MULT/MULTU/DIV/DIVU instruction.
- `muldiv_done_i`  in  1  multiply/divide result valid, 1-cycle pulse.
- `halt_req_i`  in  1  the executing instruction halts the core (jump target 0).
- `state_o`  out  `state_t`  current state: FETCH, EXEC1, EXEC2 or HALT. HALT is added to `codes::state_t`.
- `active_o`  out  1  1 while not in HALT.
- `stall_o`  out  1  the current state is held this cycle.
- `commit_o`  out  1  `active_o & ~stall_o`; the datapath gates all architectural writes with it.
- `retired_o`  out  `RETIRE_W`  count of completed instructions (see Configuration).

## Operation
- Internal state: `state_o` plus a `pending` flag for an outstanding multiply/divide.
- `mem_stall` = `ram_access_i & ram_waitrequest_i & active_o`.
- `md_stall` = (EXEC2) & ((`muldiv_start_i` & ~`pending`) | (`pending` & ~`muldiv_done_i`)).
- `stall_o` = `mem_stall | md_stall`. In HALT, `stall_o`=0.
- Transitions when `stall_o`=0:
  - FETCH -> EXEC1.
  - EXEC1 -> EXEC2.
  - EXEC2 -> FETCH, or EXEC2 -> HALT if `halt_req_i`=1 in that cycle.
  - HALT -> HALT; it is left only by reset.
- When `stall_o`=1, the state is held.
- `pending`:
  - Set at the edge ending an EXEC2 cycle with `muldiv_start_i`=1 and `pending`=0.
  - Cleared at the edge where `muldiv_done_i`=1 while `pending`=1.
  - `muldiv_done_i` is ignored while `pending`=0, including a done coinciding with the start cycle.
  - `muldiv_start_i` is ignored while `pending`=1.
- Memory and muldiv stalls are independent. If both apply, the state advances only when both are clear.
- `halt_req_i` is sampled only in the EXEC2 cycle that advances. It is ignored in other states and in stalled EXEC2 cycles.
- `retired_o` increments by 1 at every EXEC2 advance, including the halting instruction. It wraps from all-ones to 0.

## Timing
- Reset values (asserted asynchronously, held while `reset`=1):
  - `state_o`=FETCH, `active_o`=1, `stall_o` combinational from inputs, `pending`=0, `retired_o`=0.
- First FETCH occurs in the first cycle after `reset` deasserts.
- Unstalled instruction: exactly 3 cycles, one each in FETCH, EXEC1 and EXEC2.
- Each cycle with `mem_stall`=1 lengthens the current state by one cycle.
- Muldiv: start seen in EXEC2 cycle t, done seen in cycle t+k (k≥1). EXEC2 then occupies k+1 cycles and FETCH follows at t+k+1.
- `stall_o` and `commit_o` are combinational from the current state and inputs. There is no registered lag.
- HALT is entered the cycle after the halting EXEC2. From then on `active_o`=0 and `commit_o`=0.
- Reset asserted mid-stall or mid-muldiv returns to FETCH immediately and clears `pending`. Any later `muldiv_done_i` is then ignored.

## Configuration
- `CPU_SEQ_RETIRE_COUNT_EN` defined: the `retired_o` counter is implemented as specified.
- `CPU_SEQ_RETIRE_COUNT_EN` undefined: no counter register is built. `retired_o` is tied to 0.
- All other behaviour is identical with or without the macro.

## Test plan
- Basic sequencing: reset, then 9 cycles with no stall inputs -> states F,E1,E2 repeated three times, `commit_o`=1 every cycle, `retired_o`=3.
- Memory stall: `ram_access_i`=1 with `ram_waitrequest_i`=1 for 2 cycles in EXEC1 -> EXEC1 lasts 3 cycles, `stall_o`=1 and `commit_o`=0 for exactly those 2 cycles.
- Muldiv: `muldiv_start_i` in EXEC2, `muldiv_done_i` pulse 4 cycles later -> EXEC2 lasts 5 cycles, FETCH on the next cycle, `retired_o` +1 exactly once.
- Halt: `halt_req_i`=1 in an unstalled EXEC2 after 2 instructions -> HALT next cycle, `active_o`=0, `retired_o`=3. Further stimulus changes nothing.
- Async reset mid-muldiv: reset pulse while `pending`=1, then a late `muldiv_done_i` -> state FETCH during reset, `pending`=0, the late done has no effect, sequencing resumes at F,E1,E2.
- Counter wrap (macro defined, `RETIRE_W`=4): 16 instructions -> `retired_o` returns to 0. With the macro undefined, `retired_o`=0 throughout.
